// File: rtl/can_tx_serializer_pkg.sv
// Shared constants and state encoding for the CAN field serializer.
package can_tx_serializer_pkg;

   localparam int          CAN_CRC_W    = 15;
   localparam logic [14:0] CAN_CRC_POLY = 15'h4599;
   localparam logic        RECESSIVE    = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_DATA  = 3'd1,
      ST_WAIT  = 3'd2,
      ST_CRC   = 3'd3,
      ST_DELIM = 3'd4
   } state_e;

endpackage

// File: rtl/can_tx_serializer_if.sv
// Request, CRC-engine and serial-output bundle between the serializer and its environment.
interface can_tx_serializer_if #(
   parameter int DATA_W = 64,
   parameter int CRC_W  = 15
);
   logic              start;
   logic [DATA_W-1:0] data_in;
   logic [6:0]        bit_cnt;
   logic [CRC_W-1:0]  checksum;
   logic              crc_rst_n;
   logic              crc_din;
   logic [15:0]       crc_size;
   logic              tx_bit;
   logic              tx_valid;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output start, data_in, bit_cnt, checksum,
      input  crc_rst_n, crc_din, crc_size, tx_bit, tx_valid, busy, done, err
   );

   modport slave (
      input  start, data_in, bit_cnt, checksum,
      output crc_rst_n, crc_din, crc_size, tx_bit, tx_valid, busy, done, err
   );
endinterface

// File: rtl/can_tx_serializer.sv
// Serializes a data field, waits for the external CRC engine, then sends the CRC and a
// recessive delimiter. All outputs are registered alongside the state transitions.
module can_tx_serializer
   import can_tx_serializer_pkg::*;
#(
   parameter int DATA_W  = 64,
   parameter int CRC_W   = CAN_CRC_W,
   parameter int CRC_LAT = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   can_tx_serializer_if.slave  bus
);

   localparam logic [6:0] LAT_CNT = 7'(CRC_LAT);
   localparam logic [6:0] CRC_CNT = 7'(CRC_W);

   state_e            state_q;
   logic [DATA_W-1:0] shift_q;
   logic [6:0]        cnt_q;
   logic [CRC_W-1:0]  shadow_q;
   logic              tx_bit_q;
   logic              tx_valid_q;
   logic              crc_din_q;
   logic              crc_rst_n_q;
   logic              busy_q;
   logic              done_q;
   logic              err_q;
   logic [15:0]       crc_size_q;
   logic              len_ok_s;

   assign len_ok_s = (bus.bit_cnt != 7'd0) && (32'(bus.bit_cnt) <= 32'(DATA_W));

   // Registers hold the bit currently on the line; shift_q/shadow_q hold the bits still to go.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         shift_q     <= '0;
         cnt_q       <= 7'd0;
         shadow_q    <= '0;
         tx_bit_q    <= RECESSIVE;
         tx_valid_q  <= 1'b0;
         crc_din_q   <= 1'b0;
         crc_rst_n_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         crc_size_q  <= 16'd0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.start && len_ok_s) begin
                  state_q     <= ST_DATA;
                  shift_q     <= bus.data_in << 1;
                  cnt_q       <= bus.bit_cnt;
                  crc_size_q  <= {9'd0, bus.bit_cnt};
                  tx_bit_q    <= bus.data_in[DATA_W-1];
                  crc_din_q   <= bus.data_in[DATA_W-1];
                  tx_valid_q  <= 1'b1;
                  crc_rst_n_q <= 1'b1;
                  busy_q      <= 1'b1;
               end else if (bus.start) begin
                  err_q <= 1'b1;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_DATA: begin
               if (cnt_q == 7'd1) begin
                  state_q    <= ST_WAIT;
                  cnt_q      <= LAT_CNT;
                  tx_bit_q   <= RECESSIVE;
                  tx_valid_q <= 1'b0;
                  crc_din_q  <= 1'b0;
               end else begin
                  cnt_q     <= cnt_q - 7'd1;
                  shift_q   <= shift_q << 1;
                  tx_bit_q  <= shift_q[DATA_W-1];
                  crc_din_q <= shift_q[DATA_W-1];
               end
            end
            ST_WAIT: begin
               if (cnt_q == 7'd1) begin
                  state_q    <= ST_CRC;
                  cnt_q      <= CRC_CNT;
                  shadow_q   <= bus.checksum << 1;
                  tx_bit_q   <= bus.checksum[CRC_W-1];
                  tx_valid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 7'd1;
               end
            end
            ST_CRC: begin
               if (cnt_q == 7'd1) begin
                  state_q  <= ST_DELIM;
                  tx_bit_q <= RECESSIVE;
               end else begin
                  cnt_q    <= cnt_q - 7'd1;
                  shadow_q <= shadow_q << 1;
                  tx_bit_q <= shadow_q[CRC_W-1];
               end
            end
            ST_DELIM: begin
               state_q     <= ST_IDLE;
               tx_bit_q    <= RECESSIVE;
               tx_valid_q  <= 1'b0;
               crc_rst_n_q <= 1'b0;
               busy_q      <= 1'b0;
               done_q      <= 1'b1;
            end
            default: begin
               state_q     <= ST_IDLE;
               tx_bit_q    <= RECESSIVE;
               tx_valid_q  <= 1'b0;
               crc_din_q   <= 1'b0;
               crc_rst_n_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.tx_bit    = tx_bit_q;
   assign bus.tx_valid  = tx_valid_q;
   assign bus.crc_din   = crc_din_q;
   assign bus.crc_rst_n = crc_rst_n_q;
   assign bus.crc_size  = crc_size_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_can_tx_serializer.sv
// Directed bench for can_tx_serializer with a bit-serial CRC-15 engine model attached.
module tb_can_tx_serializer;

   localparam int DATA_W  = 64;
   localparam int CRC_W   = 15;
   localparam int CRC_LAT = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   logic [14:0] crc_q;
   logic [15:0] crc_n_q;
   bit          stream[$];
   int          wait_cyc, busy_cyc, done_cnt, err_cnt;

   can_tx_serializer_if #(.DATA_W(DATA_W), .CRC_W(CRC_W)) bus ();

   can_tx_serializer #(.DATA_W(DATA_W), .CRC_W(CRC_W), .CRC_LAT(CRC_LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
      logic [14:0] r;
      r = {c[13:0], 1'b0};
      if (b ^ c[14]) r = r ^ 15'h4599;
      return r;
   endfunction

   function automatic logic [14:0] golden_crc(input logic [63:0] d, input int n);
      logic [14:0] c = 15'h0000;
      for (int i = 0; i < n; i++) c = crc_step(c, d[63-i]);
      return c;
   endfunction

   // CRC engine: cleared by crc_rst_n, consumes exactly crc_size bits, then holds.
   always_ff @(posedge clk) begin
      if (!bus.crc_rst_n) begin
         crc_q   <= 15'h0000;
         crc_n_q <= 16'd0;
      end else if (crc_n_q < bus.crc_size) begin
         crc_q   <= crc_step(crc_q, bus.crc_din);
         crc_n_q <= crc_n_q + 16'd1;
      end
   end
   assign bus.checksum = crc_q;

   always @(negedge clk) begin
      if (bus.tx_valid) stream.push_back(bus.tx_bit);
      if (bus.busy && !bus.tx_valid) wait_cyc++;
      if (bus.busy) busy_cyc++;
      if (bus.done) done_cnt++;
      if (bus.err) err_cnt++;
   end

   task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] take(input int lo, input int n);
      logic [63:0] v = 64'd0;
      for (int i = 0; i < n; i++) v = {v[62:0], 1'(stream[lo+i])};
      return v;
   endfunction

   task automatic clear_mon();
      @(posedge clk);
      #1;
      stream.delete();
      wait_cyc = 0; busy_cyc = 0; done_cnt = 0; err_cnt = 0;
   endtask

   task automatic send(input logic [63:0] d, input logic [6:0] n);
      @(negedge clk);
      bus.start = 1'b1; bus.data_in = d; bus.bit_cnt = n;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (bus.busy && k < 300) begin
         @(negedge clk);
         k++;
      end
      check_vec({tag, "_timeout"}, 64'(k < 300), 64'd1);
      repeat (2) @(negedge clk);
   endtask

   // Checks a completed ABCD frame against the expected stream.
   task automatic check_abcd(input string tag);
      check_vec({tag, "_len"},   64'(stream.size()), 64'd32);
      if (stream.size() == 32) begin
         check_vec({tag, "_data"},  take(0, 16),  64'h0000_0000_0000_ABCD);
         check_vec({tag, "_crc"},   take(16, 15), 64'(golden_crc(64'hABCD_0000_0000_0000, 16)));
         check_vec({tag, "_delim"}, take(31, 1),  64'd1);
      end
      check_vec({tag, "_wait"}, 64'(wait_cyc), 64'(CRC_LAT));
      check_vec({tag, "_busy"}, 64'(busy_cyc), 64'(16 + CRC_LAT + CRC_W + 1));
      check_vec({tag, "_done"}, 64'(done_cnt), 64'd1);
   endtask

   initial begin
      bus.start = 1'b0; bus.data_in = 64'd0; bus.bit_cnt = 7'd0;
      #12;
      check_vec("reset_out", {bus.tx_bit, bus.tx_valid, bus.crc_din, bus.crc_rst_n,
                              bus.busy, bus.done, bus.err, bus.crc_size},
                {1'b1, 6'b000000, 16'h0000});
      @(negedge clk);
      rst_n = 1'b1;

      // Basic 16-bit frame
      clear_mon();
      send(64'hABCD_0000_0000_0000, 7'd16);
      check_vec("basic_size",  64'(bus.crc_size), 64'd16);
      check_vec("basic_first", {bus.busy, bus.tx_valid, bus.tx_bit, bus.crc_rst_n}, 64'hF);
      wait_idle("basic");
      check_abcd("basic");

      // Shortest field: single 0 bit, remaining data bits set to catch mis-selection
      clear_mon();
      send(64'h7FFF_FFFF_FFFF_FFFF, 7'd1);
      wait_idle("short");
      check_vec("short_len", 64'(stream.size()), 64'd17);
      if (stream.size() == 17) begin
         check_vec("short_bit",   take(0, 1),  64'd0);
         check_vec("short_crc",   take(1, 15), 64'd0);
         check_vec("short_delim", take(16, 1), 64'd1);
      end
      check_vec("short_busy", 64'(busy_cyc), 64'(1 + CRC_LAT + CRC_W + 1));

      // Full-width field
      clear_mon();
      send(64'h8123_4567_89AB_CDEF, 7'd64);
      wait_idle("full");
      check_vec("full_len", 64'(stream.size()), 64'd80);
      if (stream.size() == 80) begin
         check_vec("full_data", take(0, 64),  64'h8123_4567_89AB_CDEF);
         check_vec("full_crc",  take(64, 15), 64'(golden_crc(64'h8123_4567_89AB_CDEF, 64)));
      end

      // Illegal lengths 0 and 65
      clear_mon();
      send(64'hFFFF_0000_0000_0000, 7'd0);
      check_vec("ill0_err", {bus.err, bus.busy}, 64'b10);
      @(negedge clk);
      check_vec("ill0_err_clr", 64'(bus.err), 64'd0);
      send(64'hFFFF_0000_0000_0000, 7'd65);
      check_vec("ill65_err", {bus.err, bus.busy}, 64'b10);
      repeat (3) @(negedge clk);
      check_vec("ill_err_cnt", 64'(err_cnt), 64'd2);
      check_vec("ill_quiet", {32'(busy_cyc), 32'(stream.size())}, 64'd0);

      // Start while busy is ignored
      clear_mon();
      send(64'hABCD_0000_0000_0000, 7'd16);
      repeat (3) @(negedge clk);
      send(64'hFFFF_FFFF_FFFF_FFFF, 7'd8);
      wait_idle("busy");
      check_abcd("busy");
      check_vec("busy_no_err", 64'(err_cnt), 64'd0);

      // Reset during the CRC state, asynchronous to the clock
      clear_mon();
      send(64'hABCD_0000_0000_0000, 7'd16);
      repeat (20) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_vec("rst_mid_out", {bus.tx_bit, bus.tx_valid, bus.crc_din, bus.crc_rst_n,
                                bus.busy, bus.done, bus.err, bus.crc_size},
                {1'b1, 6'b000000, 16'h0000});
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_vec("rst_no_done", 64'(done_cnt), 64'd0);
      clear_mon();
      send(64'hABCD_0000_0000_0000, 7'd16);
      wait_idle("after_rst");
      check_abcd("after_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
